vcve2_vagu: RTL and testbench

VCVE2_VAGU -- requirements
Module: vcve2_vagu

---
 rtl/vcve2_vagu.sv | 198 +++++++++++++++++++
 tb/tb_vcve2_vagu.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vcve2_vagu.sv
// ---------------------------------------------------------------------------
// vcve2_vagu -- vector load/store address generation unit.
//
// A start request latches a base address, a stride (or the unit stride
// implied by the element width), the element width and the vector length.
// The unit then issues one address request per element until element vl-1
// is accepted, and closes the sequence with a single-cycle done pulse.
//
// Request handshake (valid/ready):
//   addr_valid_o is high in every ISSUE cycle. A request transfers in the
//   cycle where addr_valid_o & addr_ready_i are both high. While the request
//   is waiting, addr_o, be_o, elem_idx_o, last_o and we_o do not change.
//   addr_valid_o never depends on addr_ready_i.
//
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   start_i          begin a sequence (only sampled in IDLE)
//   store_i          1 = store, 0 = load
//   base_addr_i      byte address of element 0
//   stride_i         byte stride (ignored when unit_stride_i = 1)
//   unit_stride_i    stride equals element size in bytes
//   vsew_i           element width: 3'b000 = 8, 3'b001 = 16, 3'b010 = 32 bit
//   vl_i             element count
//   flush_i          abort; returns to IDLE without a done/err pulse
//   addr_ready_i     downstream accepts the current request
//   addr_valid_o     request valid
//   addr_o           byte address of the current element
//   be_o             byte enables inside the 32-bit word
//   we_o             latched store_i
//   elem_idx_o       index of the current element
//   last_o           current request is element vl-1
//   busy_o           not in IDLE
//   done_o           single-cycle completion pulse
//   err_o            single-cycle error pulse, coincident with done_o
//   dbg_state_o      current FSM state (0 = IDLE, 1 = ISSUE, 2 = DONE)
// ---------------------------------------------------------------------------
module vcve2_vagu #(
  parameter int unsigned VL_W = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            store_i,
  input  logic [31:0]     base_addr_i,
  input  logic [31:0]     stride_i,
  input  logic            unit_stride_i,
  input  logic [2:0]      vsew_i,
  input  logic [VL_W-1:0] vl_i,
  input  logic            flush_i,
  input  logic            addr_ready_i,
  output logic            addr_valid_o,
  output logic [31:0]     addr_o,
  output logic [3:0]      be_o,
  output logic            we_o,
  output logic [VL_W-1:0] elem_idx_o,
  output logic            last_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic [1:0]      dbg_state_o
);

  localparam logic [2:0] VSEW_8  = 3'b000;
  localparam logic [2:0] VSEW_16 = 3'b001;
  localparam logic [2:0] VSEW_32 = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic            we_q;
  logic            err_q;
  logic [2:0]      sew_q;
  logic [VL_W-1:0] vl_q;
  logic [VL_W-1:0] idx_q;
  logic [31:0]     addr_q;
  logic [31:0]     stride_q;

  logic            sew_ok;
  logic [1:0]      align_mask;
  logic            start_err;
  logic [31:0]     stride_eff;
  logic            accept;
  logic            is_issue;
  logic            is_last;
  logic            hs;

  // Start-time checks. align_mask selects the low address bits that must be
  // zero for the requested element width.
  always_comb begin
    sew_ok     = 1'b1;
    align_mask = 2'b00;
    case (vsew_i)
      VSEW_8:  align_mask = 2'b00;
      VSEW_16: align_mask = 2'b01;
      VSEW_32: align_mask = 2'b11;
      default: sew_ok     = 1'b0;
    endcase
    start_err  = !sew_ok
              || (|(base_addr_i[1:0] & align_mask))
              || (!unit_stride_i && (|(stride_i[1:0] & align_mask)));
    stride_eff = unit_stride_i ? (32'd1 << vsew_i[1:0]) : stride_i;
  end

  assign accept   = (state_q == IDLE) && start_i && !flush_i;
  assign is_issue = (state_q == ISSUE);
  // vl_q is never 0 in ISSUE, so vl_q-1 cannot wrap here; idx_q stops at
  // vl_q-1 and therefore never overflows even for the maximum length.
  assign is_last  = is_issue && (idx_q == (vl_q - VL_W'(1)));
  assign hs       = is_issue && addr_ready_i;

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; flush overrides everything, including a start.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = (start_err || (vl_i == '0)) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (hs && is_last) begin
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Sequence registers. A handshake coinciding with flush is seen by the
  // downstream side but leaves the internal pointer where it was.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      sew_q    <= 3'b000;
      vl_q     <= '0;
      idx_q    <= '0;
      addr_q   <= 32'd0;
      stride_q <= 32'd0;
    end else if (accept) begin
      we_q     <= store_i;
      err_q    <= start_err;
      sew_q    <= vsew_i;
      vl_q     <= vl_i;
      idx_q    <= '0;
      addr_q   <= base_addr_i;
      stride_q <= stride_eff;
    end else if (hs && !is_last && !flush_i) begin
      idx_q    <= idx_q + VL_W'(1);
      addr_q   <= addr_q + stride_q;
    end
  end

  // Byte enables; SEW16 addresses are halfword aligned so the shift is 0 or 2.
  logic [3:0] be_raw;
  always_comb begin
    be_raw = 4'b0000;
    case (sew_q)
      VSEW_8:  be_raw = 4'b0001 << addr_q[1:0];
      VSEW_16: be_raw = 4'b0011 << addr_q[1:0];
      VSEW_32: be_raw = 4'b1111;
      default: be_raw = 4'b0000;
    endcase
  end

  // Request fields are forced to 0 outside ISSUE so stale values never leak.
  assign addr_valid_o = is_issue;
  assign addr_o       = is_issue ? addr_q : 32'd0;
  assign be_o         = is_issue ? be_raw : 4'b0000;
  assign elem_idx_o   = is_issue ? idx_q : '0;
  assign last_o       = is_last;
  assign we_o         = we_q;
  assign busy_o       = (state_q != IDLE);
  // A flush in the DONE cycle suppresses the completion pulse.
  assign done_o       = (state_q == DONE) && !flush_i;
  assign err_o        = done_o && err_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_vcve2_vagu.sv
// ---------------------------------------------------------------------------
// Self-checking bench for vcve2_vagu. A narrow VL_W keeps the maximum-length
// sequence short. Expected addresses come from base + i*stride arithmetic and
// are held in an expected queue that is popped on every accepted request.
// ---------------------------------------------------------------------------
module tb_vcve2_vagu;
  localparam int VL_W = 6;

  logic            clk;
  logic            rst;
  logic            start;
  logic            store;
  logic [31:0]     base;
  logic [31:0]     stride;
  logic            unit;
  logic [2:0]      vsew;
  logic [VL_W-1:0] vl;
  logic            flush;
  logic            ready;
  logic            addr_valid;
  logic [31:0]     addr;
  logic [3:0]      be;
  logic            we;
  logic [VL_W-1:0] idx;
  logic            last;
  logic            busy;
  logic            done;
  logic            err;
  logic [1:0]      dbg_state;

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  vcve2_vagu #(.VL_W(VL_W)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .store_i       (store),
    .base_addr_i   (base),
    .stride_i      (stride),
    .unit_stride_i (unit),
    .vsew_i        (vsew),
    .vl_i          (vl),
    .flush_i       (flush),
    .addr_ready_i  (ready),
    .addr_valid_o  (addr_valid),
    .addr_o        (addr),
    .be_o          (be),
    .we_o          (we),
    .elem_idx_o    (idx),
    .last_o        (last),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned sew_bytes(input logic [2:0] s);
    if (s == 3'd0) return 1;
    if (s == 3'd1) return 2;
    if (s == 3'd2) return 4;
    return 0;
  endfunction

  function automatic logic m_err(input logic [2:0] s, input logic [31:0] b,
                                 input logic [31:0] sd, input logic u);
    int unsigned n = sew_bytes(s);
    if (n == 0) return 1'b1;
    if ((b % n) != 0) return 1'b1;
    if (!u && ((sd % n) != 0)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_addr(input logic [31:0] b, input logic [31:0] sd,
                                         input logic u, input logic [2:0] s,
                                         input int unsigned i);
    logic [31:0] stp = u ? 32'(sew_bytes(s)) : sd;
    return b + stp * i;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] s, input logic [31:0] a);
    int unsigned n = sew_bytes(s);
    int unsigned m = ((1 << n) - 1) << (a % 4);
    return m[3:0];
  endfunction

  // Runs one complete sequence and checks every request against the model.
  task automatic test_sequence(input logic st, input logic [31:0] b, input logic [31:0] sd,
                               input logic u, input logic [2:0] s, input logic [VL_W-1:0] n,
                               input logic rand_rdy, input logic [31:0] rdy_pat,
                               input logic poke_start);
    int i = 0;
    int cyc = 0;
    logic [31:0] ea;
    exp_q.delete();
    for (int k = 0; k < int'(n); k++) exp_q.push_back(m_addr(b, sd, u, s, k));
    start = 1'b1; store = st; base = b; stride = sd; unit = u; vsew = s; vl = n;
    ready = 1'b0; flush = 1'b0;
    settle();
    vectors++;
    if (busy !== 1'b0 || addr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL seq_idle_before_start busy=%0b valid=%0b expected busy=0 valid=0", busy, addr_valid);
    end
    step();
    // Scramble the inputs to show the unit works from latched copies.
    start = 1'b0; base = $urandom; stride = $urandom; store = ~st;
    vsew = 3'($urandom_range(0, 7)); vl = VL_W'($urandom);
    while (exp_q.size() != 0 && cyc < 8 * int'(n) + 16) begin
      ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_pat[cyc % 32];
      start = (poke_start && cyc == 1);
      settle();
      ea = exp_q[0];
      vectors++;
      if (addr_valid !== 1'b1 || addr !== ea || be !== m_be(s, ea) || idx !== VL_W'(i) ||
          last !== (i == int'(n) - 1) || we !== st || busy !== 1'b1 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL seq_req i=%0d got valid=%0b addr=%h be=%b idx=%0d last=%0b we=%0b done=%0b expected valid=1 addr=%h be=%b idx=%0d last=%0b we=%0b done=0",
                 i, addr_valid, addr, be, idx, last, we, done, ea, m_be(s, ea), i, (i == int'(n) - 1), st);
      end
      if (ready) begin
        void'(exp_q.pop_front());
        i++;
      end
      cyc++;
      step();
    end
    start = 1'b0; ready = 1'b0;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL seq_timeout remaining=%0d expected remaining=0", exp_q.size());
    end
    settle();
    vectors++;
    if (done !== 1'b1 || err !== 1'b0 || addr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL seq_done done=%0b err=%0b valid=%0b expected done=1 err=0 valid=0", done, err, addr_valid);
    end
    step();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || addr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL seq_back_idle busy=%0b done=%0b valid=%0b expected busy=0 done=0 valid=0", busy, done, addr_valid);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; store = 1'b0; base = '0; stride = '0; unit = 1'b0;
    vsew = '0; vl = '0; flush = 1'b0; ready = 1'b0;
    step(); step();
    vectors++;
    if ({addr_valid, addr, be, we, idx, last, busy, done, err, dbg_state} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs valid=%0b addr=%h be=%b we=%0b idx=%0d last=%0b busy=%0b done=%0b err=%0b state=%0d expected all 0",
               addr_valid, addr, be, we, idx, last, busy, done, err, dbg_state);
    end
    // Next cycle has rst low; the following sequence starts in this very cycle.
    rst = 1'b0;
  endtask

  task automatic test_unit_stride_sew32();
    test_sequence(1'b0, 32'h1000, 32'h0, 1'b1, 3'd2, VL_W'(4), 1'b0, 32'hFFFF_FFFF, 1'b0);
  endtask

  task automatic test_strided_sew8_store();
    test_sequence(1'b1, 32'h2001, 32'h11, 1'b0, 3'd0, VL_W'(3), 1'b0, 32'hFFFF_FFFD, 1'b0);
  endtask

  task automatic test_wrap();
    test_sequence(1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1, 3'd1, VL_W'(3), 1'b0, 32'hFFFF_FFFF, 1'b0);
  endtask

  task automatic test_errors();
    logic [2:0]      e_sew [5] = '{3'b111, 3'd1, 3'd2, 3'd1, 3'd0};
    logic [31:0]     e_base[5] = '{32'h100, 32'h3001, 32'h1002, 32'h3000, 32'h3000};
    logic [31:0]     e_strd[5] = '{32'h4, 32'h2, 32'h4, 32'h3, 32'h1};
    logic            e_unit[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [VL_W-1:0] e_vl  [5] = '{VL_W'(4), VL_W'(4), VL_W'(4), VL_W'(4), VL_W'(0)};
    logic [2:0] s; logic [31:0] b; logic [31:0] sd; logic u; logic [VL_W-1:0] n; logic ee;
    for (int t = 0; t < 17; t++) begin
      if (t < 5) begin
        s = e_sew[t]; b = e_base[t]; sd = e_strd[t]; u = e_unit[t]; n = e_vl[t];
      end else begin
        n = VL_W'($urandom_range(1, 20));
        do begin
          s = 3'($urandom_range(0, 7)); b = $urandom; sd = $urandom; u = 1'($urandom_range(0, 1));
        end while (!m_err(s, b, sd, u));
      end
      ee = m_err(s, b, sd, u);
      start = 1'b1; vsew = s; base = b; stride = sd; unit = u; vl = n; store = 1'b1;
      ready = 1'b1; flush = 1'b0;
      step();
      start = 1'b0;
      settle();
      vectors++;
      if (done !== 1'b1 || err !== ee || addr_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL err_response case=%0d done=%0b err=%0b valid=%0b expected done=1 err=%0b valid=0",
                 t, done, err, addr_valid, ee);
      end
      step();
      vectors++;
      if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || addr_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL err_back_idle case=%0d done=%0b err=%0b busy=%0b valid=%0b expected all 0",
                 t, done, err, busy, addr_valid);
      end
    end
    ready = 1'b0;
  endtask

  task automatic test_flush_abort();
    start = 1'b1; store = 1'b0; base = 32'h4000; stride = '0; unit = 1'b1; vsew = 3'd2;
    vl = VL_W'(8); ready = 1'b1; flush = 1'b0;
    step();
    start = 1'b0;
    step(); step();
    // Third request (index 2) is accepted together with the flush.
    flush = 1'b1;
    settle();
    vectors++;
    if (addr_valid !== 1'b1 || idx !== VL_W'(2) || addr !== 32'h4008) begin
      miscompares++;
      $display("FAIL flush_elem2 valid=%0b idx=%0d addr=%h expected valid=1 idx=2 addr=00004008", addr_valid, idx, addr);
    end
    step();
    flush = 1'b0;
    settle();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || addr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_to_idle busy=%0b done=%0b valid=%0b expected 0 0 0", busy, done, addr_valid);
    end
    step();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_no_done done=%0b busy=%0b expected 0 0", done, busy);
    end
    // Flush and start together in IDLE: flush wins.
    start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    settle();
    vectors++;
    if (busy !== 1'b0 || addr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_beats_start busy=%0b valid=%0b expected 0 0", busy, addr_valid);
    end
    // Flush during the DONE cycle of an empty (vl=0) sequence: no pulse.
    step();
    start = 1'b1; vl = '0; vsew = 3'd0;
    step();
    start = 1'b0; flush = 1'b1;
    settle();
    vectors++;
    if (done !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_in_done done=%0b err=%0b expected 0 0", done, err);
    end
    step();
    flush = 1'b0;
    ready = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_done_idle busy=%0b done=%0b expected 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid_issue();
    start = 1'b1; store = 1'b1; base = 32'h5003; stride = 32'h5; unit = 1'b0; vsew = 3'd0;
    vl = VL_W'(8); ready = 1'b0; flush = 1'b0;
    step();
    start = 1'b0;
    settle();
    vectors++;
    if (addr_valid !== 1'b1 || addr !== 32'h5003) begin
      miscompares++;
      $display("FAIL rst_mid_pre valid=%0b addr=%h expected valid=1 addr=00005003", addr_valid, addr);
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if ({addr_valid, addr, be, we, idx, last, busy, done, err} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_issue valid=%0b addr=%h be=%b we=%0b idx=%0d last=%0b busy=%0b done=%0b err=%0b expected all 0",
               addr_valid, addr, be, we, idx, last, busy, done, err);
    end
  endtask

  task automatic test_start_during_issue();
    test_sequence(1'b0, 32'h6000, 32'h8, 1'b0, 3'd2, VL_W'(5), 1'b0, 32'hFFFF_FFF5, 1'b1);
    step();
    vectors++;
    if (busy !== 1'b0 || addr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL no_queued_start busy=%0b valid=%0b expected 0 0", busy, addr_valid);
    end
  endtask

  task automatic test_back_to_back_max_vl();
    test_sequence(1'b1, $urandom, 32'h0, 1'b1, 3'd0, VL_W'((1 << VL_W) - 1), 1'b0, 32'hFFFF_FFFF, 1'b0);
  endtask

  task automatic test_random();
    logic [2:0] s; int unsigned nb; logic [31:0] b; logic [31:0] sd;
    for (int r = 0; r < 12; r++) begin
      s  = 3'($urandom_range(0, 2));
      nb = sew_bytes(s);
      b  = $urandom & ~(nb - 1);
      sd = $urandom & ~(nb - 1);
      test_sequence(1'($urandom_range(0, 1)), b, sd, 1'($urandom_range(0, 1)), s,
                    VL_W'($urandom_range(1, 20)), 1'b1, 32'h0, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_unit_stride_sew32();
    test_strided_sew8_store();
    test_wrap();
    test_errors();
    test_flush_abort();
    test_unit_stride_sew32();
    test_reset_mid_issue();
    test_strided_sew8_store();
    test_start_during_issue();
    test_back_to_back_max_vl();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
